// File: rtl/golden_response_checker.sv
// -----------------------------------------------------------------------------
// golden_response_checker
//
// Purpose:
//   Compares live (vector, response) samples from a small combinational circuit
//   against a golden truth table that is loaded beforehand, one entry per input
//   vector. It pulses on every mismatch, keeps a saturating mismatch count,
//   captures the first failing sample, and reports completion once every input
//   vector has been checked at least once.
//
// Ports:
//   CK               in   clock, rising edge
//   reset            in   synchronous active-high reset
//   start_load       in   pulse: (re)start golden table load at entry 0
//   load_valid       in   golden entry valid (accepted only in LOAD)
//   load_data        in   golden response, entries in vector order 0..2**N_IN-1
//   load_ready       out  high in LOAD
//   chk_valid        in   live sample valid (accepted only in CHECK)
//   chk_vec          in   vector applied to the circuit under test
//   chk_resp         in   circuit response to chk_vec
//   chk_ready        out  high in CHECK
//   mismatch         out  registered one-cycle pulse per failing sample
//   mismatch_count   out  saturating mismatch count
//   first_fail_valid out  a mismatch has been captured
//   first_fail_vec   out  vector of the first mismatch
//   first_fail_resp  out  response observed at the first mismatch
//   done             out  every vector has been covered
//   pass             out  done with zero mismatches
//   busy             out  state is LOAD or CHECK
// -----------------------------------------------------------------------------
module golden_response_checker #(
   parameter int N_IN  = 2,
   parameter int N_OUT = 1,
   parameter int CNT_W = 8
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             start_load,
   input  logic             load_valid,
   input  logic [N_OUT-1:0] load_data,
   output logic             load_ready,
   input  logic             chk_valid,
   input  logic [N_IN-1:0]  chk_vec,
   input  logic [N_OUT-1:0] chk_resp,
   output logic             chk_ready,
   output logic             mismatch,
   output logic [CNT_W-1:0] mismatch_count,
   output logic             first_fail_valid,
   output logic [N_IN-1:0]  first_fail_vec,
   output logic [N_OUT-1:0] first_fail_resp,
   output logic             done,
   output logic             pass,
   output logic             busy
);

   localparam int                DEPTH    = 2 ** N_IN;
   localparam logic [N_IN-1:0]   PTR_LAST = N_IN'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [N_IN-1:0]    ptr_q, ptr_d;
   logic [DEPTH-1:0]   cov_q, cov_d;
   logic               mm_q, mm_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ffv_q, ffv_d;
   logic [N_IN-1:0]    ffvec_q, ffvec_d;
   logic [N_OUT-1:0]   ffresp_q, ffresp_d;

   // Golden table. Contents are not reset; they are only meaningful after a
   // complete load, which is the only way into CHECK.
   logic [N_OUT-1:0]   golden_mem [DEPTH];
   logic               mem_we;
   logic [N_OUT-1:0]   golden_rd;
   logic               sample_bad;
   logic [DEPTH-1:0]   vec_onehot;

   // One-hot decode of the sampled vector, used to mark coverage.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_onehot
         assign vec_onehot[gi] = (chk_vec == N_IN'(gi));
      end
   endgenerate

   // Table read is combinational so the compare result can be registered on
   // the sample edge and the mismatch pulse appears exactly one cycle later.
   assign golden_rd  = golden_mem[chk_vec];
   assign sample_bad = (chk_resp != golden_rd);

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      cov_d    = cov_q;
      mm_d     = 1'b0;
      cnt_d    = cnt_q;
      ffv_d    = ffv_q;
      ffvec_d  = ffvec_q;
      ffresp_d = ffresp_q;
      mem_we   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_load) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end
         end

         ST_LOAD: begin
            // A restart takes priority over a simultaneous write.
            if (start_load) begin
               ptr_d = '0;
            end else if (load_valid) begin
               mem_we = 1'b1;
               ptr_d  = ptr_q + N_IN'(1);
               if (ptr_q == PTR_LAST) begin
                  state_d  = ST_CHECK;
                  cov_d    = '0;
                  cnt_d    = '0;
                  ffv_d    = 1'b0;
                  ffvec_d  = '0;
                  ffresp_d = '0;
               end
            end
         end

         ST_CHECK: begin
            // start_load wins over a sample in the same cycle; the sample is
            // dropped and produces no mismatch pulse.
            if (start_load) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end else if (chk_valid) begin
               mm_d  = sample_bad;
               cov_d = cov_q | vec_onehot;
               if (sample_bad) begin
                  if (cnt_q != CNT_MAX) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
                  if (!ffv_q) begin
                     ffv_d    = 1'b1;
                     ffvec_d  = chk_vec;
                     ffresp_d = chk_resp;
                  end
               end
               if (&cov_d) begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            // Results hold until CHECK is re-entered after a full reload.
            if (start_load) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CK) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         cov_q    <= '0;
         mm_q     <= 1'b0;
         cnt_q    <= '0;
         ffv_q    <= 1'b0;
         ffvec_q  <= '0;
         ffresp_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cov_q    <= cov_d;
         mm_q     <= mm_d;
         cnt_q    <= cnt_d;
         ffv_q    <= ffv_d;
         ffvec_q  <= ffvec_d;
         ffresp_q <= ffresp_d;
      end
   end

   always_ff @(posedge CK) begin
      if (mem_we && !reset) begin
         golden_mem[ptr_q] <= load_data;
      end
   end

   assign load_ready       = (state_q == ST_LOAD);
   assign chk_ready        = (state_q == ST_CHECK);
   assign busy             = (state_q == ST_LOAD) || (state_q == ST_CHECK);
   assign done             = (state_q == ST_DONE);
   assign pass             = done && (cnt_q == '0);
   assign mismatch         = mm_q;
   assign mismatch_count   = cnt_q;
   assign first_fail_valid = ffv_q;
   assign first_fail_vec   = ffvec_q;
   assign first_fail_resp  = ffresp_q;

endmodule

// File: tb/tb_golden_response_checker.sv
// -----------------------------------------------------------------------------
// tb_golden_response_checker
//
// Self-checking bench for golden_response_checker (N_IN=2, N_OUT=1, CNT_W=2 so
// counter saturation is reachable). A reference model predicts each sample's
// outcome when it is driven; the prediction is queued and popped when the
// registered result appears one cycle later.
// -----------------------------------------------------------------------------
module tb_golden_response_checker;

   localparam int N_IN  = 2;
   localparam int N_OUT = 1;
   localparam int CNT_W = 2;

   logic             CK = 1'b0;
   logic             reset;
   logic             start_load;
   logic             load_valid;
   logic [N_OUT-1:0] load_data;
   logic             load_ready;
   logic             chk_valid;
   logic [N_IN-1:0]  chk_vec;
   logic [N_OUT-1:0] chk_resp;
   logic             chk_ready;
   logic             mismatch;
   logic [CNT_W-1:0] mismatch_count;
   logic             first_fail_valid;
   logic [N_IN-1:0]  first_fail_vec;
   logic [N_OUT-1:0] first_fail_resp;
   logic             done;
   logic             pass;
   logic             busy;

   golden_response_checker #(
      .N_IN (N_IN),
      .N_OUT(N_OUT),
      .CNT_W(CNT_W)
   ) u_dut (
      .CK              (CK),
      .reset           (reset),
      .start_load      (start_load),
      .load_valid      (load_valid),
      .load_data       (load_data),
      .load_ready      (load_ready),
      .chk_valid       (chk_valid),
      .chk_vec         (chk_vec),
      .chk_resp        (chk_resp),
      .chk_ready       (chk_ready),
      .mismatch        (mismatch),
      .mismatch_count  (mismatch_count),
      .first_fail_valid(first_fail_valid),
      .first_fail_vec  (first_fail_vec),
      .first_fail_resp (first_fail_resp),
      .done            (done),
      .pass            (pass),
      .busy            (busy)
   );

   always #5 CK = ~CK;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       mm;
      logic [1:0] cnt;
      logic       dn;
      logic       ffv;
      logic [1:0] ffvec;
      logic       ffresp;
   } exp_t;

   exp_t sb_q[$];

   // Reference model state
   logic [3:0] m_gold;
   logic [1:0] m_cnt;
   logic [3:0] m_cov;
   logic       m_ffv;
   logic [1:0] m_ffvec;
   logic       m_ffresp;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_cnt = '0; m_cov = '0; m_ffv = 1'b0; m_ffvec = '0; m_ffresp = 1'b0;
   endtask

   task automatic load_table(input logic [3:0] g);
      start_load = 1'b1;
      tick();
      start_load = 1'b0;
      check_val("load_ready_in_load", {31'd0, load_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = g[i];
         tick();
      end
      load_valid = 1'b0;
      m_gold = g; m_cnt = '0; m_cov = '0; m_ffv = 1'b0; m_ffvec = '0; m_ffresp = 1'b0;
      $display("load table=%b chk_ready=%0b", g, chk_ready);
      check_val("chk_ready_after_load", {31'd0, chk_ready}, 32'd1);
   endtask

   // Drive one sample; the model predicts its outcome and queues it, the
   // registered result is popped and compared one cycle later.
   task automatic sample(input logic [1:0] vec, input logic resp);
      exp_t e;
      logic bad_s;
      logic [1:0] v;
      v = vec;
      bad_s = (resp != m_gold[v]);
      if (bad_s) begin
         if (m_cnt != 2'b11) m_cnt = m_cnt + 2'd1;
         if (!m_ffv) begin
            m_ffv = 1'b1; m_ffvec = vec; m_ffresp = resp;
         end
      end
      m_cov[v] = 1'b1;
      e.mm = bad_s; e.cnt = m_cnt; e.dn = (m_cov == 4'hF);
      e.ffv = m_ffv; e.ffvec = m_ffvec; e.ffresp = m_ffresp;
      sb_q.push_back(e);
      chk_valid = 1'b1;
      chk_vec   = vec;
      chk_resp  = resp;
      tick();
      chk_valid = 1'b0;
      chk_resp  = 'x;
      e = sb_q.pop_front();
      $display("sample vec=%b resp=%b mismatch=%b count=%0d done=%b", vec, resp, mismatch, mismatch_count, done);
      check_val("mismatch", {31'd0, mismatch}, {31'd0, e.mm});
      check_val("count", {30'd0, mismatch_count}, {30'd0, e.cnt});
      check_val("done", {31'd0, done}, {31'd0, e.dn});
      check_val("busy", {31'd0, busy}, {31'd0, ~e.dn});
      check_val("pass", {31'd0, pass}, {31'd0, e.dn && (e.cnt == 2'd0)});
      check_val("ff_valid", {31'd0, first_fail_valid}, {31'd0, e.ffv});
      if (e.ffv) begin
         check_val("ff_vec", {30'd0, first_fail_vec}, {30'd0, e.ffvec});
         check_val("ff_resp", {31'd0, first_fail_resp}, {31'd0, e.ffresp});
      end
   endtask

   initial begin
      reset = 1'b0; start_load = 1'b0; load_valid = 1'b0; load_data = '0;
      chk_valid = 1'b0; chk_vec = '0; chk_resp = '0; m_gold = '0;
      m_cnt = '0; m_cov = '0; m_ffv = 1'b0; m_ffvec = '0; m_ffresp = 1'b0;

      // Reset state
      do_reset();
      check_val("rst_outs", {22'd0, load_ready, chk_ready, mismatch, mismatch_count,
                             first_fail_valid, done, pass, busy}, 32'd0);
      check_val("rst_ffvec", {30'd0, first_fail_vec}, 32'd0);

      // XOR golden, all correct
      load_table(4'b0110);
      sample(2'b00, 1'b0); sample(2'b01, 1'b1); sample(2'b10, 1'b1); sample(2'b11, 1'b0);
      check_val("xor_pass", {31'd0, pass}, 32'd1);

      // Trojan injection: wrong response on vector 11
      load_table(4'b0110);
      sample(2'b00, 1'b0); sample(2'b01, 1'b1); sample(2'b10, 1'b1); sample(2'b11, 1'b1);
      check_val("troj_ffvec", {30'd0, first_fail_vec}, 32'd3);
      check_val("troj_pass", {31'd0, pass}, 32'd0);

      // Coverage with repeats
      load_table(4'b0110);
      sample(2'b00, 1'b1); sample(2'b00, 1'b1); sample(2'b01, 1'b1); sample(2'b10, 1'b1);
      sample(2'b11, 1'b0);
      check_val("cov_count", {30'd0, mismatch_count}, 32'd2);
      check_val("cov_ffvec", {30'd0, first_fail_vec}, 32'd0);

      // Saturation
      load_table(4'b0000);
      sample(2'b00, 1'b1); sample(2'b01, 1'b1); sample(2'b00, 1'b1);
      sample(2'b01, 1'b1); sample(2'b10, 1'b1); sample(2'b11, 1'b1);
      check_val("sat_count", {30'd0, mismatch_count}, 32'd3);

      // Gating in DONE: sample ignored, results hold
      chk_valid = 1'b1; chk_vec = 2'b00; chk_resp = 1'b0;
      tick();
      chk_valid = 1'b0;
      $display("done-gating mismatch=%b count=%0d done=%b", mismatch, mismatch_count, done);
      check_val("done_gate_mm", {31'd0, mismatch}, 32'd0);
      check_val("done_gate_cnt", {30'd0, mismatch_count}, 32'd3);
      check_val("done_gate_done", {31'd0, done}, 32'd1);

      // Reset mid-load
      start_load = 1'b1; tick(); start_load = 1'b0;
      load_valid = 1'b1; load_data = 1'b1; tick(); tick(); load_valid = 1'b0;
      do_reset();
      $display("reset-mid-load load_ready=%b busy=%b", load_ready, busy);
      check_val("rst_load_ready", {31'd0, load_ready}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_count", {30'd0, mismatch_count}, 32'd0);

      // Gating in IDLE
      chk_valid = 1'b1; chk_vec = 2'b01; chk_resp = 1'b1;
      tick();
      chk_valid = 1'b0;
      check_val("idle_gate", {29'd0, mismatch, chk_ready, busy}, 32'd0);

      // Full reload, then start_load collides with a sample in CHECK
      load_table(4'b0110);
      start_load = 1'b1; chk_valid = 1'b1; chk_vec = 2'b11; chk_resp = 1'b1;
      tick();
      start_load = 1'b0; chk_valid = 1'b0;
      $display("collide mismatch=%b load_ready=%b", mismatch, load_ready);
      check_val("collide_mm", {31'd0, mismatch}, 32'd0);
      check_val("collide_state", {30'd0, load_ready, chk_ready}, 32'd2);

      // Finish that load; load_valid in CHECK must not touch the table
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1; load_data = m_gold[i]; tick();
      end
      load_valid = 1'b0;
      m_cnt = '0; m_cov = '0; m_ffv = 1'b0;
      check_val("reload_chk_ready", {31'd0, chk_ready}, 32'd1);
      load_valid = 1'b1; load_data = 1'b1; tick(); load_valid = 1'b0;
      check_val("chk_gate_state", {30'd0, load_ready, chk_ready}, 32'd1);
      check_val("chk_gate_cnt", {30'd0, mismatch_count}, 32'd0);
      sample(2'b00, 1'b0); sample(2'b01, 1'b1); sample(2'b10, 1'b1); sample(2'b11, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
